// File: rtl/obi_sram_arbiter.sv
// rtl/obi_sram_arbiter.sv - round-robin arbiter sharing one OBI subordinate among NUM_MGR managers
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   mgr_req_i / mgr_gnt_o    per-manager A-phase request / grant
//   mgr_addr_i, mgr_we_i,    packed per-manager A-phase payload (manager i in slice i)
//   mgr_be_i, mgr_wdata_i
//   mgr_rvalid_o             per-manager R-phase valid, routed by the in-order ID FIFO
//   mgr_rready_i             per-manager R-phase ready
//   mgr_rdata_o, mgr_err_o   R-phase data / error, broadcast to all managers
//   sbr_req_o .. sbr_wdata_o A-phase to the subordinate
//   sbr_gnt_i                subordinate grant
//   sbr_rvalid_i, sbr_rdata_i, sbr_err_i  R-phase from the subordinate
//   sbr_rready_o             R-phase ready to the subordinate
module obi_sram_arbiter #(
  parameter int unsigned NUM_MGR    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [NUM_MGR-1:0]                mgr_req_i,
  output logic [NUM_MGR-1:0]                mgr_gnt_o,
  input  logic [NUM_MGR*ADDR_WIDTH-1:0]     mgr_addr_i,
  input  logic [NUM_MGR-1:0]                mgr_we_i,
  input  logic [NUM_MGR*DATA_WIDTH/8-1:0]   mgr_be_i,
  input  logic [NUM_MGR*DATA_WIDTH-1:0]     mgr_wdata_i,
  output logic [NUM_MGR-1:0]                mgr_rvalid_o,
  input  logic [NUM_MGR-1:0]                mgr_rready_i,
  output logic [DATA_WIDTH-1:0]             mgr_rdata_o,
  output logic                              mgr_err_o,
  output logic                              sbr_req_o,
  output logic [ADDR_WIDTH-1:0]             sbr_addr_o,
  output logic                              sbr_we_o,
  output logic [DATA_WIDTH/8-1:0]           sbr_be_o,
  output logic [DATA_WIDTH-1:0]             sbr_wdata_o,
  input  logic                              sbr_gnt_i,
  input  logic                              sbr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             sbr_rdata_i,
  input  logic                              sbr_err_i,
  output logic                              sbr_rready_o
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = $clog2(NUM_MGR);
  localparam int unsigned PTR_WIDTH = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    ARB,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] prio_q, prio_d;
  logic [IDX_WIDTH-1:0] lock_q, lock_d;
  logic [IDX_WIDTH-1:0] rr_sel, cand, sel;
  logic                 rr_found;
  logic                 pending;
  logic                 push, pop;

  logic [IDX_WIDTH-1:0] fifo_mem [MAX_OUTST];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 fifo_full, fifo_empty;
  logic [IDX_WIDTH-1:0] head;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(MAX_OUTST - 1)) begin
      return '0;
    end
    return p + PTR_WIDTH'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_WIDTH'(MAX_OUTST));
  assign head       = fifo_mem[rd_ptr_q];

  // Round-robin search: first requesting index at or above prio_q, wrapping.
  // When nobody requests, rr_sel falls back to prio_q whose request is low.
  always_comb begin
    rr_sel   = prio_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_MGR; k++) begin
      cand = IDX_WIDTH'((int'(prio_q) + k) % int'(NUM_MGR));
      if (!rr_found && mgr_req_i[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // A locked selection survives a manager dropping its request; the
  // subordinate then simply sees sbr_req_o low until the grant arrives.
  always_comb begin
    sel     = (state_q == HOLD) ? lock_q : rr_sel;
    pending = reset_ni & mgr_req_i[sel];
  end

  // A-phase mux and grant. A full FIFO blocks the request outright, so a
  // same-cycle pop cannot make room for a push.
  always_comb begin
    sbr_req_o   = pending & ~fifo_full;
    push        = sbr_req_o & sbr_gnt_i;
    mgr_gnt_o   = '0;
    sbr_addr_o  = '0;
    sbr_we_o    = 1'b0;
    sbr_be_o    = '0;
    sbr_wdata_o = '0;
    if (push) begin
      mgr_gnt_o[sel] = 1'b1;
    end
    if (pending) begin
      sbr_addr_o  = mgr_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
      sbr_we_o    = mgr_we_i[sel];
      sbr_be_o    = mgr_be_i[sel*BE_WIDTH +: BE_WIDTH];
      sbr_wdata_o = mgr_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic for the arbitration FSM and the priority pointer.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    prio_d  = prio_q;
    case (state_q)
      ARB: begin
        if (sbr_req_o && !sbr_gnt_i) begin
          state_d = HOLD;
          lock_d  = sel;
        end
      end
      HOLD: begin
        if (sbr_gnt_i) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (push) begin
      prio_d = (sel == IDX_WIDTH'(NUM_MGR - 1)) ? '0 : sel + IDX_WIDTH'(1);
    end
  end

  // R-phase routing. With nothing outstanding the response is swallowed.
  always_comb begin
    sbr_rready_o = ~reset_ni | fifo_empty | mgr_rready_i[head];
    pop          = reset_ni & sbr_rvalid_i & sbr_rready_o & ~fifo_empty;
    mgr_rvalid_o = '0;
    if (reset_ni && sbr_rvalid_i && !fifo_empty) begin
      mgr_rvalid_o[head] = 1'b1;
    end
    mgr_rdata_o = reset_ni ? sbr_rdata_i : '0;
    mgr_err_o   = reset_ni & sbr_err_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ARB;
      prio_q   <= '0;
      lock_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// tb/tb_obi_sram_arbiter.sv - randomized and directed bench for obi_sram_arbiter against a queue-based model
module tb_obi_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_rready;
  logic [N*AW-1:0] mgr_addr;
  logic [N*BW-1:0] mgr_be;
  logic [N*DW-1:0] mgr_wdata;
  logic [DW-1:0]   mgr_rdata;
  logic            mgr_err;
  logic            sbr_req, sbr_we, sbr_gnt, sbr_rvalid, sbr_err, sbr_rready;
  logic [AW-1:0]   sbr_addr;
  logic [BW-1:0]   sbr_be;
  logic [DW-1:0]   sbr_wdata, sbr_rdata;

  always #5 clk = ~clk;

  obi_sram_arbiter #(
    .NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt), .mgr_addr_i(mgr_addr),
    .mgr_we_i(mgr_we), .mgr_be_i(mgr_be), .mgr_wdata_i(mgr_wdata),
    .mgr_rvalid_o(mgr_rvalid), .mgr_rready_i(mgr_rready),
    .mgr_rdata_o(mgr_rdata), .mgr_err_o(mgr_err),
    .sbr_req_o(sbr_req), .sbr_addr_o(sbr_addr), .sbr_we_o(sbr_we),
    .sbr_be_o(sbr_be), .sbr_wdata_o(sbr_wdata), .sbr_gnt_i(sbr_gnt),
    .sbr_rvalid_i(sbr_rvalid), .sbr_rdata_i(sbr_rdata), .sbr_err_i(sbr_err),
    .sbr_rready_o(sbr_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: priority pointer, optional locked manager, queue of issuers.
  int           m_prio;
  bit           m_held;
  int           m_lock;
  int           id_q[$];
  logic [N-1:0] e_gnt;

  // Snapshot of DUT outputs at the last sample point, for directed checks.
  logic [N-1:0]  o_gnt, o_rvalid;
  logic          o_req, o_rready;
  logic [AW-1:0] o_addr;

  // Inputs are set 1 time unit after a rising edge; outputs are sampled at
  // the falling edge, then the model advances as the rising edge would.
  task automatic step();
    int            s;
    bit            pend, full, hs, pop;
    logic [N-1:0]  eg, ev;
    logic          erdy;
    logic [AW-1:0] ea;
    logic [BW+DW:0] epay;
    #4;
    o_gnt    = mgr_gnt;
    o_rvalid = mgr_rvalid;
    o_req    = sbr_req;
    o_rready = sbr_rready;
    o_addr   = sbr_addr;
    if (!reset_ni) begin
      id_q.delete();
      m_prio = 0;
      m_held = 0;
      m_lock = 0;
      e_gnt  = '0;
      check("rst_gnt", mgr_gnt, 0);
      check("rst_sbr_req", sbr_req, 0);
      check("rst_rvalid", mgr_rvalid, 0);
      check("rst_rready", sbr_rready, 1);
      check("rst_payload", {sbr_addr, sbr_we, sbr_be, sbr_wdata}, 0);
      check("rst_rdata", {mgr_err, mgr_rdata}, 0);
    end else begin
      full = (id_q.size() == MO);
      s = -1;
      if (m_held) s = m_lock;
      else begin
        for (int k = 0; k < N; k++) begin
          if (s < 0 && mgr_req[(m_prio + k) % N]) s = (m_prio + k) % N;
        end
      end
      pend = 0;
      if (s >= 0) pend = mgr_req[s];
      hs   = pend && !full && sbr_gnt;
      eg   = hs ? (N'(1) << s) : '0;
      ea   = '0;
      epay = '0;
      if (pend) begin
        ea   = mgr_addr[s*AW +: AW];
        epay = {mgr_we[s], mgr_be[s*BW +: BW], mgr_wdata[s*DW +: DW]};
      end
      ev   = '0;
      erdy = 1'b1;
      if (id_q.size() > 0) begin
        erdy = mgr_rready[id_q[0]];
        if (sbr_rvalid) ev = N'(1) << id_q[0];
      end
      check("sbr_req", sbr_req, pend && !full);
      check("sbr_addr", sbr_addr, ea);
      check("sbr_payload", {sbr_we, sbr_be, sbr_wdata}, epay);
      check("mgr_gnt", mgr_gnt, eg);
      check("mgr_rvalid", mgr_rvalid, ev);
      check("sbr_rready", sbr_rready, erdy);
      check("mgr_rdata", {mgr_err, mgr_rdata}, {sbr_err, sbr_rdata});
      pop = sbr_rvalid && erdy && (id_q.size() > 0);
      if (pop) void'(id_q.pop_front());
      if (hs) begin
        id_q.push_back(s);
        m_prio = (s + 1) % N;
      end
      if (m_held) begin
        if (sbr_gnt) m_held = 0;
      end else if (pend && !full && !sbr_gnt) begin
        m_held = 1;
        m_lock = s;
      end
      e_gnt = eg;
    end
    @(posedge clk);
    #1;
  endtask

  // A manager keeps its request and payload until granted, then may re-roll.
  task automatic new_reqs(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!mgr_req[i] || e_gnt[i]) begin
        mgr_req[i]            = ($urandom_range(0, 99) < pct);
        mgr_addr[i*AW +: AW]  = $urandom;
        mgr_we[i]             = 1'($urandom_range(0, 1));
        mgr_be[i*BW +: BW]    = BW'($urandom);
        mgr_wdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    reset_ni   = 1'b0;
    mgr_req    = '0;
    mgr_addr   = '0;
    mgr_we     = '0;
    mgr_be     = '0;
    mgr_wdata  = '0;
    mgr_rready = '1;
    sbr_gnt    = 1'b0;
    sbr_rvalid = 1'b0;
    sbr_rdata  = '0;
    sbr_err    = 1'b0;
    @(posedge clk);
    #1;

    // Reset with both managers requesting.
    mgr_req = 3'b011;
    step();
    check("reset_gnt", o_gnt, 0);
    check("reset_sbr_req", o_req, 0);
    check("reset_rready", o_rready, 1);

    // Fairness: grants alternate, responses come back to the issuer.
    reset_ni = 1'b1;
    sbr_gnt  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sbr_rvalid = (i > 0);
      rd = ((i - 1) % 2 == 1) ? 32'hB0 : 32'hA0;
      sbr_rdata = rd + DW'(i - 1);
      step();
      check("fair_gnt", o_gnt, (i % 2 == 1) ? 3'b010 : 3'b001);
      if (i > 0) check("fair_rvalid", o_rvalid, ((i - 1) % 2 == 1) ? 3'b010 : 3'b001);
    end
    mgr_req    = '0;
    sbr_gnt    = 1'b0;
    sbr_rdata  = 32'hB3;
    step();
    check("drain_rvalid", o_rvalid, 3'b010);
    sbr_rvalid = 1'b0;

    // Hold: M0 locked while the subordinate stalls, M1 waits.
    mgr_req            = 3'b001;
    mgr_addr[0 +: AW]  = 32'h100;
    mgr_addr[AW +: AW] = 32'h200;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) mgr_req[1] = 1'b1;
      sbr_gnt = (j == 3);
      step();
      check("hold_addr", o_addr, 32'h100);
    end
    check("hold_gnt", o_gnt, 3'b001);
    mgr_req[0] = 1'b0;
    sbr_gnt    = 1'b1;
    step();
    check("hold_next_gnt", o_gnt, 3'b010);

    // FIFO full: no request until a pop, then exactly one grant.
    mgr_req = 3'b011;
    step();
    check("full_req", o_req, 0);
    sbr_rvalid = 1'b1;
    step();
    check("full_pop_req", o_req, 0);
    check("full_pop_rvalid", o_rvalid, 3'b001);
    sbr_rvalid = 1'b0;
    step();
    check("full_grant", o_gnt, 3'b001);
    step();
    check("full_again_req", o_req, 0);

    // Response backpressure from head M1.
    mgr_req    = '0;
    sbr_gnt    = 1'b0;
    sbr_rvalid = 1'b1;
    mgr_rready = 3'b101;
    for (int j = 0; j < 2; j++) begin
      step();
      check("bp_rready", o_rready, 0);
      check("bp_rvalid", o_rvalid, 3'b010);
    end
    mgr_rready = '1;
    step();
    check("bp_pop_rready", o_rready, 1);
    step();
    check("bp_next_rvalid", o_rvalid, 3'b001);
    sbr_rvalid = 1'b0;

    // Mid-operation reset with two outstanding, then a spurious response.
    mgr_req = 3'b001;
    sbr_gnt = 1'b1;
    step();
    step();
    mgr_req  = '0;
    sbr_gnt  = 1'b0;
    reset_ni = 1'b0;
    step();
    reset_ni   = 1'b1;
    sbr_rvalid = 1'b1;
    step();
    check("spurious_rvalid", o_rvalid, 0);
    check("spurious_rready", o_rready, 1);
    sbr_rvalid = 1'b0;

    // Randomized traffic with an occasional reset.
    for (int c = 0; c < 800; c++) begin
      new_reqs(60);
      sbr_gnt    = ($urandom_range(0, 99) < 60);
      sbr_rvalid = ($urandom_range(0, 99) < 50);
      mgr_rready = N'($urandom);
      sbr_rdata  = $urandom;
      sbr_err    = 1'($urandom_range(0, 1));
      reset_ni   = !(c % 250 == 249);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
